fp_mult_arbiter: RTL

Round-robin scheduler that shares one pipelined single-precision `fp_mult` core among `N_REQ` independent requesters. Each requester gets a valid/ready request channel and a valid/ready response channel. The arbiter issues at most one operation per cycle into the multiplier and tags each in-flight operation with its requester ID, so every result returns to its owner. If an owner stalls its response, the whole multiplier pipeline freezes through `clk_en`. It sits between the Avalon-slave front ends (CPU, DMA) and the `fp_mult` instance.

---
 rtl/fp_arb_pkg.sv | 24 ++
 rtl/fp_mult_arbiter_rr_arbiter.sv | 50 +++++
 rtl/fp_mult_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and defaults for the fp_mult arbiter and its sub-modules.
package fp_arb_pkg;

    // Pipeline depth of the fp_mult core, in clock-enabled cycles.
    localparam int DEFAULT_LATENCY = 11;

    // Tag id field is sized for the largest supported requester count (8).
    localparam int MAX_ID_W = 3;

    // Core status flags, in the bit order the core presents them.
    typedef struct packed {
        logic ov;
        logic un;
        logic zero;
        logic nan;
    } fp_flags_t;

    // Ownership tag that travels alongside each operation in the core.
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts one past
// the last accepted winner; the pointer moves only when a grant is taken.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    req,
    input  logic            en,
    input  logic            advance,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] last_d;
    logic [ID_W-1:0] idx;
    logic            found;

    // Priority search from last_q+1, wrapping modulo N.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
        gnt    = '0;
        gnt_id = '0;
        idx    = '0;
        found  = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = ID_W'((int'(last_q) + off) % N);
            if (en && req[idx] && !found) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end

    // Next pointer: follows the winner only on an accepted transfer.
    always_comb begin
        last_d = advance ? gnt_id : last_q;
    end

    // Pointer register; resets to N-1 so requester 0 has first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) last_q <= ID_W'(N - 1);
        else          last_q <= last_d;
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one pipelined fp_mult core among N_REQ requesters. Each issued
// operation carries an owner tag through a shift pipe that mirrors the core;
// a stalled owner freezes core, operands and tags together via mult_clk_en.
module fp_mult_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = DEFAULT_LATENCY,
    parameter int ID_W    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    output logic [N_REQ-1:0]    resp_valid,
    input  logic [N_REQ-1:0]    resp_ready,
    output logic [31:0]         resp_result,
    output logic [3:0]          resp_flags,
    output logic [31:0]         mult_dataa,
    output logic [31:0]         mult_datab,
    output logic                mult_clk_en,
    input  logic [31:0]         mult_result,
    input  logic [3:0]          mult_flags,
    output logic                busy
);

    // Stage 0 pairs with the operand registers; stage LATENCY pairs with mult_result.
    tag_t            tag_q [LATENCY+1];
    tag_t            tag_d;
    tag_t            out_tag;
    logic [31:0]     dataa_q, dataa_d;
    logic [31:0]     datab_q, datab_d;
    logic [31:0]     a_sel, b_sel;
    logic [ID_W-1:0] gnt_id;
    logic            out_ready;
    logic            stall;
    logic            accept;
    logic            arb_en;
    fp_flags_t       core_flags;

    assign out_tag = tag_q[LATENCY];

    // Ready of the requester that owns the result currently at the core output.
    always_comb begin
        out_ready = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (out_tag.id == MAX_ID_W'(i)) out_ready = resp_ready[i];
        end
    end

    assign stall       = out_tag.valid && !out_ready;
    assign mult_clk_en = !stall;
    // Grants are suppressed during reset so req_ready reads 0 while reset_n is low.
    assign arb_en      = !stall && reset_n;
    assign accept      = |(req_valid & req_ready);

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req_valid),
        .en      (arb_en),
        .advance (accept),
        .gnt     (req_ready),
        .gnt_id  (gnt_id)
    );

    // Operand mux driven by the one-hot grant; only feeds registers.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                a_sel = req_a[i*32 +: 32];
                b_sel = req_b[i*32 +: 32];
            end
        end
    end

    // Issue-stage next state: load winner operands on accept, otherwise hold.
    always_comb begin
        dataa_d     = accept ? a_sel : dataa_q;
        datab_d     = accept ? b_sel : datab_q;
        tag_d.valid = accept;
        tag_d.id    = accept ? MAX_ID_W'(gnt_id) : '0;
    end

    // Operand registers feeding the core.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dataa_q <= '0;
            datab_q <= '0;
        end else begin
            dataa_q <= dataa_d;
            datab_q <= datab_d;
        end
    end

    // Tag pipe: shifts in lockstep with the core, frozen while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: this array is reset because its valid bits are control state; a pure data RAM would not be.
            for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
        end else if (!stall) begin
            tag_q[0] <= tag_d;
            for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Busy whenever any registered tag stage holds a live operation.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i <= LATENCY; i++) busy = busy | tag_q[i].valid;
    end

    // Steer the shared result to its owner.
    always_comb begin
        resp_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = out_tag.valid && (out_tag.id == MAX_ID_W'(i));
        end
    end

    assign core_flags  = mult_flags;
    assign resp_flags  = core_flags;
    assign resp_result = mult_result;
    assign mult_dataa  = dataa_q;
    assign mult_datab  = datab_q;

endmodule
